// File: rtl/spi_xchg_sched_if.sv
// spi_xchg_sched_if: trigger, data, serial link and result signals of the SPI exchange scheduler
interface spi_xchg_sched_if #(
  parameter int DW = 15
) ();
  logic          start;
  logic          auto_en;
  logic [DW-1:0] master_dat;
  logic [DW-1:0] slave_dat;
  logic          sclk;
  logic          ss_n;
  logic          mosi;
  logic          miso;
  logic [DW:0]   master_rx;
  logic [DW:0]   slave_rx;
  logic          busy;
  logic          done;
  logic          overrun;
  logic [7:0]    xfer_cnt;
  modport master (
    output start, auto_en, master_dat, slave_dat,
    input  sclk, ss_n, mosi, miso, master_rx, slave_rx, busy, done, overrun, xfer_cnt
  );
  modport slave (
    input  start, auto_en, master_dat, slave_dat,
    output sclk, ss_n, mosi, miso, master_rx, slave_rx, busy, done, overrun, xfer_cnt
  );
endinterface

// File: rtl/spi_xchg_sched.sv
// spi_xchg_sched: full-duplex mode-0 SPI exchange of a master/slave word pair, pulse or periodic trigger
module spi_xchg_sched #(
  parameter int DW      = 15,
  parameter int CLK_DIV = 4,
  parameter int PERIOD  = 2000
) (
  input logic             clk,
  input logic             rst,
  spi_xchg_sched_if.slave xchg
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DW);
  localparam int PW = $clog2(PERIOD);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, STOP = 2'd3;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [PW-1:0] per_q, per_d;
  logic          sclk_q, sclk_d;
  logic          ss_n_q, ss_n_d;
  logic [DW-1:0] mtx_q, mtx_d, stx_q, stx_d;
  logic [DW-1:0] mrx_sr_q, mrx_sr_d, srx_sr_q, srx_sr_d;
  logic [DW:0]   mrx_q, mrx_d, srx_q, srx_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          div_end, per_hit, trig;
  always_comb begin
    div_end  = div_q == CW'(CLK_DIV - 1);
    per_hit  = xchg.auto_en && per_q == PW'(PERIOD - 1);
    trig     = xchg.start || per_hit;
    state_d  = state_q;
    div_d    = div_end ? '0 : div_q + CW'(1);
    bit_d    = bit_q;
    per_d    = (xchg.auto_en && !per_hit) ? per_q + PW'(1) : '0;
    sclk_d   = sclk_q;
    ss_n_d   = ss_n_q;
    mtx_d    = mtx_q;
    stx_d    = stx_q;
    mrx_sr_d = mrx_sr_q;
    srx_sr_d = srx_sr_q;
    mrx_d    = mrx_q;
    srx_d    = srx_q;
    done_d   = 1'b0;
    ovr_d    = ovr_q || (per_hit && state_q != IDLE);
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: state_d = trig ? LOAD : IDLE;
      LOAD: begin
        mtx_d   = xchg.master_dat;
        stx_d   = xchg.slave_dat;
        ss_n_d  = 1'b0;
        sclk_d  = 1'b0;
        bit_d   = '0;
        div_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: if (div_end) begin
        sclk_d = ~sclk_q;
        if (!sclk_q) begin
          mrx_sr_d = {mrx_sr_q[DW-2:0], stx_q[DW-1]};
          srx_sr_d = {srx_sr_q[DW-2:0], mtx_q[DW-1]};
        end else begin
          mtx_d   = mtx_q << 1;
          stx_d   = stx_q << 1;
          bit_d   = bit_q + BW'(1);
          state_d = bit_q == BW'(DW - 1) ? STOP : SHIFT;
        end
      end
      STOP: if (div_end) begin
        ss_n_d  = 1'b1;
        mrx_d   = {1'b0, mrx_sr_q};
        srx_d   = {1'b0, srx_sr_q};
        done_d  = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      per_q    <= '0;
      sclk_q   <= 1'b0;
      ss_n_q   <= 1'b1;
      mtx_q    <= '0;
      stx_q    <= '0;
      mrx_sr_q <= '0;
      srx_sr_q <= '0;
      mrx_q    <= '0;
      srx_q    <= '0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      per_q    <= per_d;
      sclk_q   <= sclk_d;
      ss_n_q   <= ss_n_d;
      mtx_q    <= mtx_d;
      stx_q    <= stx_d;
      mrx_sr_q <= mrx_sr_d;
      srx_sr_q <= srx_sr_d;
      mrx_q    <= mrx_d;
      srx_q    <= srx_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
      cnt_q    <= cnt_d;
    end
  end
  assign xchg.sclk      = sclk_q;
  assign xchg.ss_n      = ss_n_q;
  assign xchg.mosi      = mtx_q[DW-1];
  assign xchg.miso      = stx_q[DW-1];
  assign xchg.master_rx = mrx_q;
  assign xchg.slave_rx  = srx_q;
  assign xchg.busy      = state_q != IDLE;
  assign xchg.done      = done_q;
  assign xchg.overrun   = ovr_q;
  assign xchg.xfer_cnt  = cnt_q;
endmodule

// File: tb/tb_spi_xchg_sched.sv
// tb_spi_xchg_sched: directed scoreboard bench, default instance plus a short-period instance
module tb_spi_xchg_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  spi_xchg_sched_if #(.DW(15)) ifa ();
  spi_xchg_sched_if #(.DW(15)) ifb ();
  spi_xchg_sched #(.DW(15), .CLK_DIV(4), .PERIOD(2000)) u_a (.clk(clk), .rst(rst), .xchg(ifa));
  spi_xchg_sched #(.DW(15), .CLK_DIV(4), .PERIOD(100))  u_b (.clk(clk), .rst(rst), .xchg(ifb));
  int checks = 0, failures = 0, rises_a = 0, dones_a = 0, exp_a = 0, exp_b = 0;
  logic pa_sclk = 1'b0, pa_mosi = 1'b0;
  logic [31:0] sb_a[$], sb_b[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  always @(negedge clk) begin
    if (ifa.sclk && !pa_sclk) begin
      rises_a++;
      chk("a_mosi_stable", ifa.mosi, pa_mosi);
    end
    if (ifa.done) dones_a++;
    pa_sclk = ifa.sclk;
    pa_mosi = ifa.mosi;
  end
  task automatic wait_a(input int bound, input bit extra, output int n);
    logic [15:0] held;
    n = 0;
    held = ifa.master_rx;
    do begin
      @(posedge clk);
      #1;
      n++;
      ifa.start = extra && (n == 10 || n == 60);
      if (extra && n == 5) begin
        ifa.master_dat = 15'h0F0F;
        ifa.slave_dat  = 15'h7070;
      end
      if (n == 100) chk("a_rx_hold", ifa.master_rx, held);
    end while (!ifa.done && n < bound);
    ifa.start = 1'b0;
    chk("a_done_seen", ifa.done, 1);
  endtask
  task automatic wait_b(input int bound, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ifb.done && n < bound);
    chk("b_done_seen", ifb.done, 1);
  endtask
  task automatic check_a();
    logic [31:0] e;
    chk("a_sb_nonempty", sb_a.size() != 0, 1);
    if (sb_a.size() == 0) return;
    e = sb_a.pop_front();
    exp_a++;
    chk("a_master_rx", ifa.master_rx, e[31:16]);
    chk("a_slave_rx", ifa.slave_rx, e[15:0]);
    chk("a_xfer_cnt", ifa.xfer_cnt, exp_a[7:0]);
  endtask
  task automatic check_b();
    logic [31:0] e;
    chk("b_sb_nonempty", sb_b.size() != 0, 1);
    if (sb_b.size() == 0) return;
    e = sb_b.pop_front();
    exp_b++;
    chk("b_master_rx", ifb.master_rx, e[31:16]);
    chk("b_slave_rx", ifb.slave_rx, e[15:0]);
    chk("b_xfer_cnt", ifb.xfer_cnt, exp_b[7:0]);
  endtask
  task automatic run_a(input logic [14:0] m, input logic [14:0] s, input bit extra);
    int n, r0;
    ifa.master_dat = m;
    ifa.slave_dat  = s;
    ifa.start      = 1'b1;
    sb_a.push_back({1'b0, s, 1'b0, m});
    r0 = rises_a;
    wait_a(400, extra, n);
    chk("a_latency", n, 126);
    chk("a_sclk_rises", rises_a - r0, 15);
    check_a();
  endtask
  initial begin
    int n, d0;
    ifa.start = 0; ifa.auto_en = 0; ifa.master_dat = '0; ifa.slave_dat = '0;
    ifb.start = 0; ifb.auto_en = 0; ifb.master_dat = '0; ifb.slave_dat = '0;
    step(3);
    chk("rst_ss_n", ifa.ss_n, 1);
    chk("rst_sclk", ifa.sclk, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_xfer_cnt", ifa.xfer_cnt, 0);
    rst = 1'b0;
    step(2);
    run_a(15'h5A5A, 15'h1234, 1'b0);
    step(1);
    chk("a_done_pulse", ifa.done, 0);
    chk("a_idle_busy", ifa.busy, 0);
    chk("a_idle_ss_n", ifa.ss_n, 1);
    run_a(15'h7FFF, 15'h0000, 1'b0);
    run_a(15'h0000, 15'h7FFF, 1'b0);
    step(1);
    chk("a_b2b_done_pulse", ifa.done, 0);
    d0 = dones_a;
    run_a(15'h2A55, 15'h55AA, 1'b1);
    step(200);
    chk("a_single_done", dones_a - d0, 1);
    chk("a_cnt_after_ignored", ifa.xfer_cnt, exp_a[7:0]);
    chk("a_no_overrun_start", ifa.overrun, 0);
    ifa.master_dat = 15'h3C3C; ifa.slave_dat = 15'h4321; ifa.start = 1'b1;
    step(1);
    ifa.start = 1'b0;
    step(50);
    chk("a_busy_mid", ifa.busy, 1);
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    exp_a = 0; exp_b = 0;
    chk("mid_rst_sclk", ifa.sclk, 0);
    chk("mid_rst_ss_n", ifa.ss_n, 1);
    chk("mid_rst_busy", ifa.busy, 0);
    chk("mid_rst_master_rx", ifa.master_rx, 0);
    chk("mid_rst_slave_rx", ifa.slave_rx, 0);
    chk("mid_rst_xfer_cnt", ifa.xfer_cnt, 0);
    chk("mid_rst_mosi", ifa.mosi, 0);
    step(1);
    chk("mid_rst_stays_idle", ifa.busy, 0);
    ifa.master_dat = 15'h1357; ifa.slave_dat = 15'h2468; ifa.auto_en = 1'b1;
    sb_a.push_back({16'h2468, 16'h1357});
    wait_a(2300, 1'b0, n);
    check_a();
    for (int i = 0; i < 2; i++) begin
      sb_a.push_back({16'h2468, 16'h1357});
      wait_a(2100, 1'b0, n);
      chk("a_auto_period", n, 2000);
      check_a();
    end
    chk("a_auto_no_overrun", ifa.overrun, 0);
    ifa.auto_en = 1'b0;
    ifb.master_dat = 15'h4C3B; ifb.slave_dat = 15'h0DE1; ifb.auto_en = 1'b1;
    step(50);
    chk("b_overrun_early", ifb.overrun, 0);
    sb_b.push_back({16'h0DE1, 16'h4C3B});
    wait_b(300, n);
    check_b();
    chk("b_overrun_set", ifb.overrun, 1);
    sb_b.push_back({16'h0DE1, 16'h4C3B});
    wait_b(300, n);
    chk("b_auto_period", n, 200);
    check_b();
    chk("b_overrun_sticky", ifb.overrun, 1);
    ifb.auto_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
